data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Memory-side responder for the load/store interface driven by the CPU's execute stage.
- Accepts one word-aligned read or byte-masked write per transaction over a valid/ready request channel.
- Returns read data and status over a valid/ready response channel after a fixed, parameterised wait-state latency.
- Sits between the execute/writeback path and the data store, in the memory space beside the instruction fetch path.

Parameters:
- ADDR_BITS, 8: word-index width. Depth is 2^ADDR_BITS words. Valid byte addresses are 0 .. 4*2^ADDR_BITS-1.
- LATENCY, 2: cycles from request acceptance to first rsp_valid. Must be >= 1; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_wren  input  4  byte write enables; bit i writes bits [8i+7:8i]; 4'b0000 means a read
- req_addr  input  32  byte address
- req_wdata  input  32  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts the response
- rsp_rdata  output  32  word at the address, as it was before this request's write
- rsp_err  output  1  request rejected (misaligned or out of range)

Behaviour:
- Reset, checked at the clk edge while rst=1:
  - State goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Memory array is NOT cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, the request is accepted.
  - Go to RESP if LATENCY=1, otherwise go to WAIT with the counter loaded to LATENCY-2.
- WAIT:
  - req_ready=0.
  - Counter decrements each edge.
  - At count 0, go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable.
  - On an edge with rsp_ready=1, go to IDLE: rsp_valid=0 and req_ready=1 on the next cycle.
- Latency: rsp_valid rises exactly LATENCY cycles after the accepting edge.
- Accepting edge actions:
  - Capture the old word at index req_addr[ADDR_BITS+1:2] into the response register.
  - Apply the write for every set req_wren bit.
  - Read-before-write: rsp_rdata always returns the pre-write contents.
- Error check, evaluated at acceptance:
  - Condition: req_addr[1:0]!=0, or any of req_addr[31:ADDR_BITS+2] set.
  - Result: no write occurs, rsp_rdata=0, rsp_err=1.
  - Error responses follow the same latency and handshake as normal responses.
- Only one transaction is in flight at a time.
  - Minimum spacing between acceptances is LATENCY+1 cycles when rsp_ready is held high.
  - req_valid is ignored while req_ready=0; the requester must hold req_valid and its fields until accepted.
- rsp_ready while rsp_valid=0 is ignored.
- Reset mid-transaction (WAIT or RESP):
  - Transaction is dropped with no response.
  - A write already applied at acceptance remains in memory.
- Reset and req_valid on the same edge: reset wins; nothing is accepted and nothing is written.
- Address wrap: none. Out-of-range addresses error out and never alias.
- Writes with partial req_wren leave unselected bytes unchanged.

Test Plan:
- Reset then basic read/write:
  - Write addr 0x10, wren 4'hF, wdata 0xDEADBEEF, LATENCY=2 -> rsp_valid two cycles after accept; rsp_rdata = old word; rsp_err=0.
  - Then read 0x10 -> rsp_rdata=0xDEADBEEF.
- Byte enables:
  - Word 0x10 = 0xDEADBEEF, write wren 4'b0101 with 0x11223344 -> read returns 0xDE22BE44.
- Errors:
  - Read addr 0x13 -> rsp_err=1, rsp_rdata=0.
  - Write addr 0x400 (ADDR_BITS=8) -> rsp_err=1; read of 0x0 is unchanged.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stay stable; req_ready stays 0.
  - Raise rsp_ready -> IDLE next cycle.
  - A req_valid pulse during WAIT is not accepted and causes no write.
- Back-to-back with rsp_ready=1:
  - Ten alternating write/read pairs at 0x00..0x24 -> every read matches; acceptances are spaced exactly LATENCY+1 cycles; repeat with LATENCY=1 and LATENCY=4.
- Reset mid-operation:
  - Write 0x20 = 0xCAFEF00D, assert rst in WAIT -> no rsp_valid; req_ready=1 after reset.
  - Subsequent read of 0x20 -> 0xCAFEF00D.

Source files
------------

// File: rtl/data_mem_responder.sv
// Memory-side load/store responder: one word-aligned read or byte-masked write per
// transaction, answered after a fixed wait-state latency over a valid/ready channel.
module data_mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_wren,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CW    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("data_mem_responder: LATENCY must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt, w_cnt_next;
  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic                  w_accept, w_err;
  logic [ADDR_BITS-1:0]  w_idx;

  assign w_idx    = req_addr[ADDR_BITS+1:2];
  // Misaligned or beyond the array: rejected, never aliased onto a wrapped index.
  assign w_err    = (req_addr[1:0] != 2'b00) || (|req_addr[31:ADDR_BITS+2]);
  assign w_accept = (r_state == IDLE) && req_valid;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 1) begin
            w_next = RESP;
          end else begin
            w_next     = WAIT;
            w_cnt_next = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) w_next = RESP;
        else             w_cnt_next = r_cnt - 1'b1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_rdata <= w_err ? 32'h0 : r_mem[w_idx];
        r_err   <= w_err;
      end
    end
  end

  // Array is never cleared; the write lands on the accepting edge, so the
  // response register above picks up the pre-write word.
  always_ff @(posedge clk) begin
    if (!rst && w_accept && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wren[b]) r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
